mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-ported unified memory between the core's fetch port (iaddr/instruction) and data port (daddr/read/write).
// - Sits between the pipelined core and the memory model; one transaction is outstanding at a time.
// - Data requests have priority; a starvation counter guarantees forward progress for fetch.
// PARAMETERS
// - ADDR_W      32  address width, all ports
// - DATA_W      32  data width, all ports
// - STARVE_MAX  4   consecutive data grants allowed while fetch waits (0 = strict data priority)
// PORTS
// - clk        in   1       clock, rising edge
// - rst        in   1       reset, asynchronous, active-low (asserted at 0)
// - i_req      in   1       fetch request; i_addr held stable until i_gnt
// - i_addr     in   ADDR_W  fetch address
// - i_gnt      out  1       fetch accepted by memory this cycle
// - i_rvalid   out  1       fetch data valid on i_rdata
// - i_rdata    out  DATA_W  fetch read data
// - d_req      in   1       data request; d_we/d_be/d_addr/d_wdata held stable until d_gnt
// - d_we       in   1       1 = write, 0 = read
// - d_be       in   4       byte enables
// - d_addr     in   ADDR_W  data address
// - d_wdata    in   DATA_W  write data
// - d_gnt      out  1       data request accepted this cycle
// - d_rvalid   out  1       read data / write ack valid
// - d_rdata    out  DATA_W  data read data
// - m_req      out  1       memory request, held until m_gnt
// - m_we, m_be, m_addr, m_wdata  out  1/4/ADDR_W/DATA_W  latched attributes of the owner
// - m_gnt      in   1       memory accepts m_req
// - m_rvalid   in   1       response (read data or write ack), exactly one per grant
// - m_rdata    in   DATA_W  memory read data
// BEHAVIOUR
// - FSM states: IDLE, REQ (m_req=1, wait m_gnt), RESP (wait m_rvalid).
// - IDLE: if any req, pick the owner, latch the attributes, go to REQ the next cycle. m_req is registered, so there is 1 cycle from req to m_req.
// - REQ: on m_gnt, pulse the owner's gnt in the same cycle (combinational from m_gnt), then go to RESP.
// - RESP: on m_rvalid, route the response to the owner's rvalid/rdata in the same cycle, then re-arbitrate.
//   - Pending req -> REQ directly.
//   - Otherwise -> IDLE.
// - Pick rule: data wins when both request, unless starve_cnt == STARVE_MAX (STARVE_MAX > 0); then fetch wins.
// - starve_cnt:
//   - +1 on a data win while i_req=1.
//   - Cleared on a fetch win or when i_req=0 at arbitration.
//   - Saturates at STARVE_MAX.
// - Owner and attributes are frozen from arbitration through the response; requester input changes are ignored.
// - m_rvalid in IDLE/REQ is ignored. gnt/rvalid are never asserted to the non-owner.
// - Reset values: m_req=0, m_we=0, m_be=0, m_addr=0, m_wdata=0, i_gnt=0, d_gnt=0, i_rvalid=0, d_rvalid=0, state=IDLE, starve_cnt=0.
// - rdata outputs pass m_rdata through and are don't-care when their rvalid=0.
// - Reset mid-transaction: return to IDLE at once and drop the outstanding response; no rvalid is forwarded after reset.
// CONFIGURATION
// - Macro MEM_ARB_PERF_EN defined: adds outputs perf_istall_cnt[31:0] and perf_dgrant_cnt[31:0].
//   - perf_istall_cnt: +1 every cycle i_req=1 && !i_gnt.
//   - perf_dgrant_cnt: +1 per d_gnt.
//   - Both reset to 0 and wrap at 2^32.
// - Macro undefined: no counters and no such ports; behaviour is otherwise identical.
// STRUCTURE
// - core_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP} arb_state_t.
// - core_pkg: typedef enum logic {OWN_I, OWN_D} arb_owner_t.
// - Sub-module mem_arb_pick (combinational): inputs i_req, d_req, starve_cnt; outputs winner and next starve_cnt.
// TESTING
// - i_req only, i_addr=0x100, m_gnt at cycle 2, m_rvalid with 0xDEADBEEF at cycle 4 -> m_req cycles 1-2, i_gnt cycle 2, i_rvalid + i_rdata=0xDEADBEEF cycle 4, d_* silent.
// - i_req and d_req together, d_we=1, d_addr=0x200, d_be=0x3 -> data served first (m_we=1, m_be=0x3), fetch served next via RESP->REQ with no IDLE cycle.
// - d_req held high for 10 transactions with i_req high, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D,D,D,I...
// - rst driven to 0 while in RESP, then a stray m_rvalid -> no i_rvalid/d_rvalid, all outputs at reset values, state IDLE.
// - m_gnt held low 5 cycles in REQ -> m_req and attributes stable, no gnt pulses; i_addr changed mid-wait -> m_addr unchanged.
// - MEM_ARB_PERF_EN defined, the starvation scenario above -> perf_dgrant_cnt=8, perf_istall_cnt equals the counted i_req-without-gnt cycles.

Source files
------------

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the unified-memory port arbiter.
//   arb_state_t : arbiter FSM state (idle / request to memory / awaiting response)
//   arb_owner_t : which core port owns the memory transaction in flight
//   cnt_width() : width of a counter that must hold the value max_val
// ---------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

  localparam int BE_W = 4;

  // Instruction fetches are always full-word reads.
  localparam logic [BE_W-1:0] FETCH_BE = 4'hF;

  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational arbitration rule between the fetch and data ports.
// Data wins a contested arbitration unless fetch has already lost STARVE_MAX
// contested arbitrations in a row (STARVE_MAX = 0 gives strict data priority).
// Ports:
//   i_fetch_req   fetch port is requesting
//   i_data_req    data port is requesting
//   i_starve_cnt  consecutive data wins while fetch was waiting
//   o_winner      owner of the next transaction (only meaningful if a req is up)
//   o_starve_nxt  starvation count to store if this arbitration is taken
// ---------------------------------------------------------------------------
module mem_arb_pick
  import core_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic             i_fetch_req,
  input  logic             i_data_req,
  input  logic [CNT_W-1:0] i_starve_cnt,
  output arb_owner_t       o_winner,
  output logic [CNT_W-1:0] o_starve_nxt
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(STARVE_MAX);

  logic w_starved;
  logic w_at_max;

  assign w_at_max  = (i_starve_cnt == LP_CNT_MAX);
  assign w_starved = (STARVE_MAX > 0) && w_at_max;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    o_winner     = OWN_I;
    o_starve_nxt = '0;
    if (i_data_req && !(i_fetch_req && w_starved)) begin
      o_winner = OWN_D;
    end
    // Only a data win over a waiting fetch counts as starvation; saturate.
    if ((o_winner == OWN_D) && i_fetch_req) begin
      o_starve_nxt = w_at_max ? i_starve_cnt : i_starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported unified memory between the core's fetch port and
// data port. One transaction is outstanding at a time; the owner and its
// request attributes are frozen from arbitration until the response returns.
//
// Optional feature (macro MEM_ARB_PERF_EN): adds free-running 32-bit
// performance counters perf_istall_cnt (cycles fetch waits without a grant)
// and perf_dgrant_cnt (data grants).
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   i_req/i_addr              fetch request and address
//   i_gnt/i_rvalid/i_rdata    fetch accept pulse, response valid, read data
//   d_req/d_we/d_be/d_addr/d_wdata  data request and attributes
//   d_gnt/d_rvalid/d_rdata    data accept pulse, response valid, read data
//   m_req/m_we/m_be/m_addr/m_wdata  memory request and latched attributes
//   m_gnt/m_rvalid/m_rdata    memory accept, response valid, read data
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [BE_W-1:0]   d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]       perf_istall_cnt,
  output logic [31:0]       perf_dgrant_cnt,
`endif
  // memory port
  output logic              m_req,
  output logic              m_we,
  output logic [BE_W-1:0]   m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int CNT_W = cnt_width(STARVE_MAX);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  arb_owner_t        r_owner;
  arb_owner_t        w_winner;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [CNT_W-1:0]  w_starve_nxt;
  logic              r_m_we;
  logic [BE_W-1:0]   r_m_be;
  logic [ADDR_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic              w_any_req;
  logic              w_arb_fire;

  assign w_any_req = i_req | d_req;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) u_pick (
    .i_fetch_req  (i_req),
    .i_data_req   (d_req),
    .i_starve_cnt (r_starve_cnt),
    .o_winner     (w_winner),
    .o_starve_nxt (w_starve_nxt)
  );

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and port handshakes. gnt is combinational from m_gnt and
  // rvalid from m_rvalid; both are steered only to the frozen owner.
  always_comb begin
    w_state_nxt = r_state;
    w_arb_fire  = 1'b0;
    m_req       = 1'b0;
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    i_rvalid    = 1'b0;
    d_rvalid    = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_any_req) begin
          w_arb_fire  = 1'b1;
          w_state_nxt = ARB_REQ;
        end
      end
      ARB_REQ: begin
        m_req = 1'b1;
        if (m_gnt) begin
          i_gnt       = (r_owner == OWN_I);
          d_gnt       = (r_owner == OWN_D);
          w_state_nxt = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (m_rvalid) begin
          i_rvalid = (r_owner == OWN_I);
          d_rvalid = (r_owner == OWN_D);
          // Back-to-back: a waiting requester goes straight to REQ.
          if (w_any_req) begin
            w_arb_fire  = 1'b1;
            w_state_nxt = ARB_REQ;
          end else begin
            w_state_nxt = ARB_IDLE;
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Owner, starvation count and memory attributes change only at arbitration.
  // NOTE: these datapath registers are reset because they drive the memory
  // port directly and must read as zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= OWN_I;
      r_starve_cnt <= '0;
      r_m_we       <= 1'b0;
      r_m_be       <= '0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
    end else if (w_arb_fire) begin
      r_owner      <= w_winner;
      r_starve_cnt <= w_starve_nxt;
      if (w_winner == OWN_D) begin
        r_m_we    <= d_we;
        r_m_be    <= d_be;
        r_m_addr  <= d_addr;
        r_m_wdata <= d_wdata;
      end else begin
        r_m_we    <= 1'b0;
        r_m_be    <= FETCH_BE;
        r_m_addr  <= i_addr;
        r_m_wdata <= '0;
      end
    end
  end

  assign m_we    = r_m_we;
  assign m_be    = r_m_be;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;

  // Read data is a straight pass-through; only meaningful with rvalid.
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perf_istall;
  logic [31:0] r_perf_dgrant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_istall <= '0;
      r_perf_dgrant <= '0;
    end else begin
      if (i_req && !i_gnt) r_perf_istall <= r_perf_istall + 32'd1;
      if (d_gnt)           r_perf_dgrant <= r_perf_dgrant + 32'd1;
    end
  end

  assign perf_istall_cnt = r_perf_istall;
  assign perf_dgrant_cnt = r_perf_dgrant;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter (STARVE_MAX = 4). A transaction-
// level reference model predicts every handshake; the bench also acts as the
// requesters and as the memory. Define MEM_ARB_PERF_EN to check the counters.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              m_req;
  logic              m_we;
  logic [3:0]        m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]       perf_istall_cnt;
  logic [31:0]       perf_dgrant_cnt;
`endif

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req           (i_req),
    .i_addr          (i_addr),
    .i_gnt           (i_gnt),
    .i_rvalid        (i_rvalid),
    .i_rdata         (i_rdata),
    .d_req           (d_req),
    .d_we            (d_we),
    .d_be            (d_be),
    .d_addr          (d_addr),
    .d_wdata         (d_wdata),
    .d_gnt           (d_gnt),
    .d_rvalid        (d_rvalid),
    .d_rdata         (d_rdata),
`ifdef MEM_ARB_PERF_EN
    .perf_istall_cnt (perf_istall_cnt),
    .perf_dgrant_cnt (perf_dgrant_cnt),
`endif
    .m_req           (m_req),
    .m_we            (m_we),
    .m_be            (m_be),
    .m_addr          (m_addr),
    .m_wdata         (m_wdata),
    .m_gnt           (m_gnt),
    .m_rvalid        (m_rvalid),
    .m_rdata         (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---- requester agents --------------------------------------------------
  bit          f_pend;
  logic [31:0] f_addr;
  int          f_quota;
  bit          dq_pend;
  logic        dq_we;
  logic [3:0]  dq_be;
  logic [31:0] dq_addr;
  logic [31:0] dq_wdata;
  int          d_quota;

  // ---- memory behaviour knobs (percent) and scripted overrides -----------
  int          p_fetch, p_data, p_gnt, p_rv, p_stray;
  bit          scripted;
  bit          ov_gnt, ov_rv;
  logic [31:0] ov_rdata;

  // ---- reference model: the one transaction in flight --------------------
  bit          mdl_active;   // a transaction has been arbitrated
  bit          mdl_granted;  // memory has accepted it
  bit          mdl_own_d;
  bit          mdl_seen;     // any arbitration since reset
  logic        mdl_we;
  logic [3:0]  mdl_be;
  logic [31:0] mdl_addr, mdl_wdata;
  int          mdl_starve;   // contested data wins in a row
  int          exp_istall, exp_dgrant;

  int          cyc;
  string       grant_log;
  int          n_grants;

  task automatic clear_model();
    mdl_active = 0; mdl_granted = 0; mdl_own_d = 0; mdl_seen = 0;
    mdl_we = 0; mdl_be = '0; mdl_addr = '0; mdl_wdata = '0; mdl_starve = 0;
    exp_istall = 0; exp_dgrant = 0;
    f_pend = 0; dq_pend = 0;
    grant_log = ""; n_grants = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_req"},    32'(m_req), 0);
    check({tag, "_m_we"},     32'(m_we), 0);
    check({tag, "_m_be"},     32'(m_be), 0);
    check({tag, "_m_addr"},   m_addr, 0);
    check({tag, "_m_wdata"},  m_wdata, 0);
    check({tag, "_i_gnt"},    32'(i_gnt), 0);
    check({tag, "_d_gnt"},    32'(d_gnt), 0);
    check({tag, "_i_rvalid"}, 32'(i_rvalid), 0);
    check({tag, "_d_rvalid"}, 32'(d_rvalid), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_req = 0; d_req = 0; m_gnt = 0; m_rvalid = 0;
    clear_model();
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // One clock cycle: drive inputs, predict, compare at negedge, advance model.
  task automatic run_cycle();
    bit e_mreq, e_ig, e_dg, e_irv, e_drv, e_inresp, pick_d;
    if (!f_pend && f_quota != 0 && int'($urandom_range(99)) < p_fetch) begin
      f_pend = 1; f_addr = $urandom;
      if (f_quota > 0) f_quota--;
    end
    if (!dq_pend && d_quota != 0 && int'($urandom_range(99)) < p_data) begin
      dq_pend = 1; dq_we = 1'($urandom); dq_be = 4'($urandom);
      dq_addr = $urandom; dq_wdata = $urandom;
      if (d_quota > 0) d_quota--;
    end
    i_req = f_pend;  i_addr = f_addr;
    d_req = dq_pend; d_we = dq_we; d_be = dq_be; d_addr = dq_addr; d_wdata = dq_wdata;

    e_mreq   = mdl_active && !mdl_granted;
    e_inresp = mdl_active && mdl_granted;
    if (scripted) begin
      m_gnt = ov_gnt; m_rvalid = ov_rv; m_rdata = ov_rdata;
    end else begin
      m_gnt    = e_mreq && (int'($urandom_range(99)) < p_gnt);
      m_rvalid = e_inresp ? (int'($urandom_range(99)) < p_rv)
                          : (int'($urandom_range(99)) < p_stray);
      m_rdata  = $urandom;
    end
    e_ig  = e_mreq && m_gnt && !mdl_own_d;
    e_dg  = e_mreq && m_gnt && mdl_own_d;
    e_irv = e_inresp && m_rvalid && !mdl_own_d;
    e_drv = e_inresp && m_rvalid && mdl_own_d;

    @(negedge clk);
    check($sformatf("m_req@%0d", cyc),    32'(m_req), 32'(e_mreq));
    check($sformatf("i_gnt@%0d", cyc),    32'(i_gnt), 32'(e_ig));
    check($sformatf("d_gnt@%0d", cyc),    32'(d_gnt), 32'(e_dg));
    check($sformatf("i_rvalid@%0d", cyc), 32'(i_rvalid), 32'(e_irv));
    check($sformatf("d_rvalid@%0d", cyc), 32'(d_rvalid), 32'(e_drv));
    if (e_irv) check($sformatf("i_rdata@%0d", cyc), i_rdata, m_rdata);
    if (e_drv) check($sformatf("d_rdata@%0d", cyc), d_rdata, m_rdata);
    check($sformatf("m_we@%0d", cyc),   32'(m_we), 32'(mdl_we));
    check($sformatf("m_addr@%0d", cyc), m_addr, mdl_addr);
    if (mdl_own_d || !mdl_seen) begin
      check($sformatf("m_be@%0d", cyc),    32'(m_be), 32'(mdl_be));
      check($sformatf("m_wdata@%0d", cyc), m_wdata, mdl_wdata);
    end
    if (i_gnt) begin grant_log = {grant_log, "I"}; n_grants++; end
    if (d_gnt) begin grant_log = {grant_log, "D"}; n_grants++; end
    if (i_req && !e_ig) exp_istall++;
    if (e_dg) exp_dgrant++;
    if (e_ig) f_pend = 0;
    if (e_dg) dq_pend = 0;

    // Advance: response frees the port, grant moves to waiting for response.
    if (e_inresp && m_rvalid) mdl_active = 0;
    else if (e_mreq && m_gnt) mdl_granted = 1;
    if (!mdl_active && (i_req || d_req)) begin
      pick_d = d_req && !(i_req && mdl_starve == STARVE_MAX && STARVE_MAX > 0);
      if (pick_d && i_req) mdl_starve = (mdl_starve < STARVE_MAX) ? mdl_starve + 1 : STARVE_MAX;
      else mdl_starve = 0;
      mdl_active = 1; mdl_granted = 0; mdl_seen = 1; mdl_own_d = pick_d;
      if (pick_d) begin
        mdl_we = d_we; mdl_be = d_be; mdl_addr = d_addr; mdl_wdata = d_wdata;
      end else begin
        mdl_we = 0; mdl_be = 4'hF; mdl_addr = i_addr; mdl_wdata = '0;
      end
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic script(input bit g, input bit r, input logic [31:0] rd);
    ov_gnt = g; ov_rv = r; ov_rdata = rd;
    run_cycle();
  endtask

  initial begin
    rst = 1'b0; cyc = 0;
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
    m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    f_addr = '0; dq_we = 0; dq_be = '0; dq_addr = '0; dq_wdata = '0;
    p_fetch = 0; p_data = 0; p_gnt = 0; p_rv = 0; p_stray = 0;
    f_quota = -1; d_quota = -1; scripted = 0; ov_gnt = 0; ov_rv = 0; ov_rdata = '0;

    // Single fetch: m_gnt at cycle 2, response at cycle 4.
    do_reset();
    scripted = 1;
    f_pend = 1; f_addr = 32'h100;
    script(0, 0, 0);
    script(0, 0, 0);
    script(1, 0, 0);
    script(0, 0, 0);
    script(0, 1, 32'hDEADBEEF);
    check("single_fetch_order", 32'(grant_log == "I"), 1);

    // Simultaneous requests: data first, fetch follows with no idle cycle.
    do_reset();
    f_pend = 1; f_addr = 32'h300;
    dq_pend = 1; dq_we = 1; dq_addr = 32'h200; dq_be = 4'h3; dq_wdata = 32'hCAFE0001;
    script(0, 0, 0);
    script(1, 0, 0);
    script(0, 1, 32'h0);
    script(1, 0, 0);
    script(0, 1, 32'h12345678);
    check("both_order", 32'(grant_log == "DI"), 1);

    // Memory stalls the grant; fetch address changes while waiting.
    do_reset();
    f_pend = 1; f_addr = 32'h400;
    script(0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) f_addr = 32'h4444;
      script(0, 0, 0);
    end
    script(1, 0, 0);
    script(0, 0, 0);
    script(0, 1, 32'h55AA55AA);
    check("stall_addr_frozen", m_addr, 32'h400);
    check("stall_order", 32'(grant_log == "I"), 1);

    // Starvation: fetch always waiting, data re-requests after every grant.
    do_reset();
    scripted = 0;
    p_fetch = 100; p_data = 100; f_quota = 2; d_quota = 8;
    p_gnt = 50; p_rv = 50; p_stray = 0;
    for (int k = 0; k < 300 && !(n_grants == 10 && !mdl_active); k++) run_cycle();
    $display("starvation grant order: %s", grant_log);
    check("starve_grants", 32'(n_grants), 10);
    check("starve_order", 32'(grant_log == "DDDDIDDDDI"), 1);
`ifdef MEM_ARB_PERF_EN
    check("perf_dgrant", perf_dgrant_cnt, 8);
    check("perf_istall", perf_istall_cnt, 32'(exp_istall));
`endif

    // Reset while a response is outstanding; stray response must be dropped.
    do_reset();
    p_fetch = 100; f_quota = 1; p_data = 0; d_quota = 0;
    p_gnt = 100; p_rv = 0; p_stray = 0;
    for (int k = 0; k < 10 && !mdl_granted; k++) run_cycle();
    check("rst_pre_grant", 32'(n_grants), 1);
    rst = 1'b0; i_req = 0; d_req = 0; m_rvalid = 1; m_rdata = 32'hBAD0BAD0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    check_reset_outputs("rst_hold");
    @(posedge clk); #1;
    rst = 1'b1;
    clear_model();
    p_fetch = 0; p_stray = 100;
    repeat (3) run_cycle();

    // Random traffic: light load, then heavy contention with stray responses.
    do_reset();
    p_fetch = 40; p_data = 40; f_quota = -1; d_quota = -1;
    p_gnt = 60; p_rv = 50; p_stray = 15;
    repeat (2000) run_cycle();
    p_fetch = 95; p_data = 95; p_gnt = 40; p_rv = 40; p_stray = 20;
    repeat (1500) run_cycle();
`ifdef MEM_ARB_PERF_EN
    check("rand_perf_dgrant", perf_dgrant_cnt, 32'(exp_dgrant));
    check("rand_perf_istall", perf_istall_cnt, 32'(exp_istall));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
